front_panel_ctl: RTL and testbench



---
 rtl/front_panel_ctl.sv | 183 ++++++++++++++++++
 tb/tb_front_panel_ctl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/front_panel_ctl.sv
// Front-panel action scheduler: shared debounce strobes, arbitration of
// debounced button / BMC events, and timed active-low button pulses to the PCH
// with a quiet holdoff after every pulse.
module front_panel_ctl #(
    parameter int PULSE_TICKS   = 2,
    parameter int HOLDOFF_TICKS = 8,
    parameter int FORCE_TICKS   = 48
) (
    input  logic SlowClock,
    input  logic MainReset,
    output logic Strobe16ms,
    output logic Strobe125ms,
    input  logic PwrIntr,
    input  logic PwrHoldN,
    input  logic RstIntr,
    input  logic BmcPwrReq,
    input  logic PowerGood,
    output logic PchPwrBtnN,
    output logic PchRstBtnN,
    output logic Busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PWR   = 3'd1,
        RST   = 3'd2,
        FORCE = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam logic [5:0] PULSE_LAST = 6'(PULSE_TICKS - 1);
    localparam logic [5:0] HOLD_LAST  = 6'(HOLDOFF_TICKS - 1);
    localparam logic [5:0] FORCE_LAST = 6'(FORCE_TICKS - 1);
    localparam logic [5:0] TK_MAX     = 6'd63;

    logic [11:0] pre_q, pre_d;
    logic        strobe16_q, strobe16_d;
    logic        strobe125_q, strobe125_d;
    logic        pend_pwr_q, pend_pwr_d;
    logic        pend_rst_q, pend_rst_d;
    logic        pend_force_q, pend_force_d;
    logic        hold_prev_q, hold_prev_d;
    state_t      state_q, state_d;
    logic [5:0]  tk_q, tk_d;
    logic        pwr_btn_n_q, pwr_btn_n_d;
    logic        rst_btn_n_q, rst_btn_n_d;
    logic        busy_q, busy_d;

    logic        grant_pwr;
    logic        grant_rst;
    logic        grant_force;
    logic        clear_queued;
    logic [5:0]  tk_adv;

    // Free-running prescaler and the two strobes decoded from its previous value.
    always_comb begin
        pre_d       = pre_q + 12'd1;
        strobe16_d  = (pre_q[8:0] == 9'h1FF);
        strobe125_d = (pre_q == 12'hFFF);
    end

    // Arbitration, pulse timing and preemption; outputs follow the next state.
    always_comb begin
        state_d      = state_q;
        tk_d         = tk_q;
        grant_pwr    = 1'b0;
        grant_rst    = 1'b0;
        grant_force  = 1'b0;
        clear_queued = 1'b0;
        tk_adv       = tk_q;
        if (strobe125_q && (tk_q != TK_MAX)) begin
            tk_adv = tk_q + 6'd1;
        end

        case (state_q)
            IDLE: begin
                if (pend_force_q) begin
                    state_d     = FORCE;
                    grant_force = 1'b1;
                    tk_d        = 6'd0;
                end else if (pend_rst_q) begin
                    state_d   = RST;
                    grant_rst = 1'b1;
                    tk_d      = 6'd0;
                end else if (pend_pwr_q) begin
                    state_d   = PWR;
                    grant_pwr = 1'b1;
                    tk_d      = 6'd0;
                end
            end
            PWR, RST: begin
                if (pend_force_q) begin
                    state_d     = FORCE;
                    grant_force = 1'b1;
                    tk_d        = 6'd0;
                end else if (strobe125_q && (tk_q == PULSE_LAST)) begin
                    state_d = HOLD;
                    tk_d    = 6'd0;
                end else begin
                    tk_d = tk_adv;
                end
            end
            FORCE: begin
                if (strobe125_q && (tk_q == FORCE_LAST)) begin
                    state_d      = HOLD;
                    tk_d         = 6'd0;
                    clear_queued = 1'b1;
                end else begin
                    tk_d = tk_adv;
                end
            end
            HOLD: begin
                if (pend_force_q) begin
                    state_d     = FORCE;
                    grant_force = 1'b1;
                    tk_d        = 6'd0;
                end else if (strobe125_q && (tk_q == HOLD_LAST)) begin
                    state_d = IDLE;
                    tk_d    = 6'd0;
                end else begin
                    tk_d = tk_adv;
                end
            end
            default: begin
                state_d = IDLE;
                tk_d    = 6'd0;
            end
        endcase

        pwr_btn_n_d = !((state_d == PWR) || (state_d == FORCE));
        rst_btn_n_d = (state_d != RST);
        busy_d      = (state_d != IDLE);
    end

    // Pending flags: a new event beats a same-cycle clear; a force arriving while forcing is absorbed.
    always_comb begin
        hold_prev_d  = PwrHoldN;
        pend_pwr_d   = (pend_pwr_q & ~(grant_pwr | clear_queued)) | PwrIntr | BmcPwrReq;
        pend_rst_d   = (pend_rst_q & ~(grant_rst | clear_queued)) | (RstIntr & PowerGood);
        pend_force_d = 1'b0;
        if (state_q != FORCE) begin
            pend_force_d = (pend_force_q & ~grant_force) | (hold_prev_q & ~PwrHoldN);
        end
    end

    // State register; reset drops all pending work and releases both buttons immediately.
    always_ff @(posedge SlowClock or negedge MainReset) begin
        if (!MainReset) begin
            pre_q        <= 12'd0;
            strobe16_q   <= 1'b0;
            strobe125_q  <= 1'b0;
            pend_pwr_q   <= 1'b0;
            pend_rst_q   <= 1'b0;
            pend_force_q <= 1'b0;
            hold_prev_q  <= 1'b1;
            state_q      <= IDLE;
            tk_q         <= 6'd0;
            pwr_btn_n_q  <= 1'b1;
            rst_btn_n_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            strobe16_q   <= strobe16_d;
            strobe125_q  <= strobe125_d;
            pend_pwr_q   <= pend_pwr_d;
            pend_rst_q   <= pend_rst_d;
            pend_force_q <= pend_force_d;
            hold_prev_q  <= hold_prev_d;
            state_q      <= state_d;
            tk_q         <= tk_d;
            pwr_btn_n_q  <= pwr_btn_n_d;
            rst_btn_n_q  <= rst_btn_n_d;
            busy_q       <= busy_d;
        end
    end

    assign Strobe16ms  = strobe16_q;
    assign Strobe125ms = strobe125_q;
    assign PchPwrBtnN  = pwr_btn_n_q;
    assign PchRstBtnN  = rst_btn_n_q;
    assign Busy        = busy_q;

endmodule

// File: tb/tb_front_panel_ctl.sv
// Bench for front_panel_ctl: an action-level model (remaining-tick countdowns)
// checked every cycle, plus hand-derived timing windows for the directed cases.
module tb_front_panel_ctl;

    localparam int PULSE   = 2;
    localparam int HOLDOFF = 1;
    localparam int FORCE   = 3;
    localparam int TICK    = 4096;
    localparam int BUDGET  = 20000;

    localparam int M_IDLE  = 0;
    localparam int M_PWR   = 1;
    localparam int M_RST   = 2;
    localparam int M_FORCE = 3;
    localparam int M_HOLD  = 4;

    logic slow_clock   = 1'b0;
    logic main_reset   = 1'b0;
    logic pwr_intr     = 1'b0;
    logic pwr_hold_n   = 1'b1;
    logic rst_intr     = 1'b0;
    logic bmc_pwr_req  = 1'b0;
    logic power_good   = 1'b0;
    logic strobe16;
    logic strobe125;
    logic pch_pwr_n;
    logic pch_rst_n;
    logic busy;

    int total = 0;
    int bad   = 0;
    int fail_prints = 0;

    // model state
    int m_cyc  = 0;
    bit m_s16  = 1'b0;
    bit m_s125 = 1'b0;
    int m_mode = M_IDLE;
    int m_left = 0;
    bit m_pp   = 1'b0;
    bit m_pr   = 1'b0;
    bit m_pf   = 1'b0;
    bit m_hprev = 1'b1;

    // strobe counters for the first 8192 cycles after reset release
    int run_cyc = 0;
    int n_s16 = 0;
    int n_s125 = 0;
    int n_both = 0;

    front_panel_ctl #(
        .PULSE_TICKS   (PULSE),
        .HOLDOFF_TICKS (HOLDOFF),
        .FORCE_TICKS   (FORCE)
    ) dut (
        .SlowClock   (slow_clock),
        .MainReset   (main_reset),
        .Strobe16ms  (strobe16),
        .Strobe125ms (strobe125),
        .PwrIntr     (pwr_intr),
        .PwrHoldN    (pwr_hold_n),
        .RstIntr     (rst_intr),
        .BmcPwrReq   (bmc_pwr_req),
        .PowerGood   (power_good),
        .PchPwrBtnN  (pch_pwr_n),
        .PchRstBtnN  (pch_rst_n),
        .Busy        (busy)
    );

    always #5 slow_clock = ~slow_clock;

    // Action-level model: each action owns a countdown of 125 ms strobes.
    always @(posedge slow_clock or negedge main_reset) begin
        if (!main_reset) begin
            m_cyc = 0; m_s16 = 0; m_s125 = 0; m_mode = M_IDLE; m_left = 0;
            m_pp = 0; m_pr = 0; m_pf = 0; m_hprev = 1;
        end else begin
            int  mode_before;
            bit  strobe_seen;
            bit  fall;
            mode_before = m_mode;
            strobe_seen = m_s125;
            fall = m_hprev && !pwr_hold_n;
            m_cyc++;
            m_s16  = (m_cyc % 512 == 0);
            m_s125 = (m_cyc % TICK == 0);
            if (m_mode == M_IDLE) begin
                if (m_pf)      begin m_mode = M_FORCE; m_left = FORCE; m_pf = 0; end
                else if (m_pr) begin m_mode = M_RST;   m_left = PULSE; m_pr = 0; end
                else if (m_pp) begin m_mode = M_PWR;   m_left = PULSE; m_pp = 0; end
            end else if (m_mode != M_FORCE && m_pf) begin
                m_mode = M_FORCE; m_left = FORCE; m_pf = 0;
            end else if (strobe_seen) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_mode == M_HOLD) m_mode = M_IDLE;
                    else begin
                        if (m_mode == M_FORCE) begin m_pp = 0; m_pr = 0; end
                        m_mode = M_HOLD;
                        m_left = HOLDOFF;
                    end
                end
            end
            m_pp = m_pp | pwr_intr | bmc_pwr_req;
            m_pr = m_pr | (rst_intr & power_good);
            m_pf = (mode_before == M_FORCE) ? 1'b0 : (m_pf | fall);
            m_hprev = pwr_hold_n;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge slow_clock) begin
        logic [4:0] got, want;
        got  = {strobe16, strobe125, pch_pwr_n, pch_rst_n, busy};
        want = {m_s16, m_s125,
                !(m_mode == M_PWR || m_mode == M_FORCE),
                m_mode != M_RST,
                m_mode != M_IDLE};
        total++;
        if (got !== want) begin
            bad++;
            if (fail_prints < 10) begin
                fail_prints++;
                $display("[TB] FAIL cycle_model t=%0t s16/s125/pwrn/rstn/busy got=%b want=%b", $time, got, want);
            end
        end
    end

    // Strobe pulse tally over the first 8192 cycles of the first run.
    always @(negedge slow_clock) begin
        if (!main_reset) run_cyc = 0;
        else begin
            run_cyc++;
            if (run_cyc <= 8192) begin
                if (strobe16) n_s16++;
                if (strobe125) n_s125++;
                if (strobe16 && strobe125) n_both++;
            end
        end
    end

    function automatic logic sig(input int which);
        case (which)
            0: return pch_pwr_n;
            1: return pch_rst_n;
            default: return busy;
        endcase
    endfunction

    task automatic check_output(input string name, input int actual, input int lo, input int hi);
        total++;
        if (actual < lo || actual > hi) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, required %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic wait_for(input string name, input int which, input logic level, output int n);
        n = 0;
        do begin
            @(negedge slow_clock);
            n++;
        end while (sig(which) !== level && n < BUDGET);
        if (sig(which) !== level) begin
            total++;
            bad++;
            $display("[TB] FAIL %s timeout: value=%b required=%b after %0d cycles", name, sig(which), level, n);
        end
    endtask

    task automatic apply_stimulus(input logic p, input logic r, input logic b);
        @(posedge slow_clock); #2;
        pwr_intr = p; rst_intr = r; bmc_pwr_req = b;
        @(posedge slow_clock); #2;
        pwr_intr = 0; rst_intr = 0; bmc_pwr_req = 0;
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(negedge slow_clock);
            if (busy !== 1'b0 || pch_pwr_n !== 1'b1 || pch_rst_n !== 1'b1) seen++;
        end
        check_output(name, seen, 0, 0);
    endtask

    initial begin
        int n;
        int n_total;
        #12;
        check_output("reset_outputs", int'({strobe16, strobe125, pch_pwr_n, pch_rst_n, busy}), 5'b00110, 5'b00110);
        #10 main_reset = 1'b1;

        // power short press
        apply_stimulus(1, 0, 0);
        wait_for("pwr_low", 0, 1'b0, n);
        check_output("pwr_latency", n, 2, 2);
        check_output("pwr_rst_idle", int'(pch_rst_n), 1, 1);
        wait_for("pwr_high", 0, 1'b1, n);
        check_output("pwr_len", n, (PULSE - 1) * TICK + 1, PULSE * TICK);
        wait_for("pwr_busy_drop", 2, 1'b0, n);
        check_output("pwr_hold_len", n, (HOLDOFF - 1) * TICK + 1, HOLDOFF * TICK);

        check_output("strobe16_count", n_s16, 16, 16);
        check_output("strobe125_count", n_s125, 2, 2);
        check_output("strobe_coincide", n_both, 2, 2);

        // reset press while not in S0 is dropped
        power_good = 1'b0;
        apply_stimulus(0, 1, 0);
        expect_quiet("rst_pg0_quiet", 50);

        // reset press in S0
        power_good = 1'b1;
        apply_stimulus(0, 1, 0);
        wait_for("rst_low", 1, 1'b0, n);
        check_output("rst_latency", n, 2, 2);
        wait_for("rst_high", 1, 1'b1, n);
        check_output("rst_len", n, (PULSE - 1) * TICK + 1, PULSE * TICK);
        wait_for("rst_busy_drop", 2, 1'b0, n);
        check_output("rst_hold_len", n, (HOLDOFF - 1) * TICK + 1, HOLDOFF * TICK);

        // reset and power together: reset wins, power follows after holdoff
        apply_stimulus(1, 1, 0);
        wait_for("both_rst_low", 1, 1'b0, n);
        check_output("both_rst_latency", n, 2, 2);
        check_output("both_pwr_waits", int'(pch_pwr_n), 1, 1);
        wait_for("both_rst_high", 1, 1'b1, n);
        check_output("both_rst_len", n, (PULSE - 1) * TICK + 1, PULSE * TICK);
        wait_for("both_pwr_low", 0, 1'b0, n);
        check_output("both_gap", n, (HOLDOFF - 1) * TICK + 2, HOLDOFF * TICK + 1);
        wait_for("both_pwr_high", 0, 1'b1, n);
        check_output("both_pwr_len", n, (PULSE - 1) * TICK + 1, PULSE * TICK);
        wait_for("both_busy_drop", 2, 1'b0, n);

        // long hold preempts a running power pulse; BMC request during force is discarded
        power_good = 1'b0;
        apply_stimulus(1, 0, 0);
        wait_for("force_pwr_low", 0, 1'b0, n);
        repeat (100) @(negedge slow_clock);
        @(posedge slow_clock); #2;
        pwr_hold_n = 1'b0;
        repeat (10) begin @(posedge slow_clock); #2; end
        pwr_hold_n = 1'b1;
        bmc_pwr_req = 1'b1;
        @(posedge slow_clock); #2;
        bmc_pwr_req = 1'b0;
        check_output("force_still_low", int'(pch_pwr_n), 0, 0);
        wait_for("force_high", 0, 1'b1, n);
        n_total = n + 11;
        check_output("force_len", n_total, (FORCE - 1) * TICK + 2, FORCE * TICK + 1);
        wait_for("force_busy_drop", 2, 1'b0, n);
        check_output("force_hold_len", n, (HOLDOFF - 1) * TICK + 1, HOLDOFF * TICK);
        expect_quiet("force_no_replay", 100);

        // reset asserted mid-force
        @(posedge slow_clock); #2;
        pwr_hold_n = 1'b0;
        @(posedge slow_clock); #2;
        pwr_hold_n = 1'b1;
        wait_for("rf_pwr_low", 0, 1'b0, n);
        apply_stimulus(1, 0, 0);
        repeat (200) @(negedge slow_clock);
        @(posedge slow_clock); #2;
        main_reset = 1'b0;
        #1;
        check_output("rf_async_outputs", int'({pch_pwr_n, pch_rst_n, busy}), 3'b110, 3'b110);
        repeat (3) @(posedge slow_clock);
        #2 main_reset = 1'b1;
        expect_quiet("rf_no_replay", 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
